multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the instruction and counter width.
REQ-002 The block SHALL have port clk, input, 1, the single clock, with all state on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port instr, input, DATA_WIDTH, the instruction word from instruction memory.
REQ-005 The block SHALL have port imem_req/imem_ready, output/input, 1 each, the fetch handshake.
REQ-006 The block SHALL have port dmem_req/dmem_we/dmem_ready, output/output/input, 1 each, the data-memory handshake.
REQ-007 The block SHALL have port eq, input, 1, the ALU equality flag.
REQ-008 The block SHALL have outputs ir_en, pc_en, pc_src, reg_write, alu_src, result_src (1 bit each), alu_ctrl (3 bits) and imm_src (2 bits), all datapath controls.
REQ-009 The block SHALL have outputs halted (1 bit) and cycle_cnt/instr_cnt (DATA_WIDTH each).

Function
REQ-010 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-011 FETCH SHALL assert imem_req and hold it until imem_ready; in the imem_ready cycle it SHALL pulse ir_en and go to DECODE.
REQ-012 DECODE SHALL last one cycle, latch the decoded controls, and go to EXEC; an illegal instruction SHALL go to HALT instead.
REQ-013 Legal opcodes SHALL be R-type 0110011 (ADD, SUB, AND, OR, SLT), I-type 0010011 (ADDI, ANDI, ORI, SLTI), LW 0000011, SW 0100011 and BEQ/BNE 1100011; any other opcode, funct3 or funct7 combination is illegal.
REQ-014 EXEC for R-type and I-type SHALL go to WB; EXEC for LW or SW SHALL go to MEM.
REQ-015 EXEC for a branch SHALL pulse pc_en with pc_src = eq for BEQ and pc_src = !eq for BNE, use alu_ctrl=SUB, and go to FETCH.
REQ-016 MEM SHALL hold dmem_req, with dmem_we=1 for SW, until dmem_ready; SW SHALL then pulse pc_en (pc_src=0) and go to FETCH, and LW SHALL go to WB.
REQ-017 WB SHALL pulse reg_write and pc_en (pc_src=0) for exactly one cycle, with result_src=1 for LW and 0 otherwise, then go to FETCH.
REQ-018 alu_src SHALL be 1 for I-type, LW and SW, and 0 for R-type and branches; imm_src SHALL be 00 for I-type/LW, 01 for SW and 10 for branches.
REQ-019 With zero-wait memories the latency SHALL be: R/I 4 cycles, LW 5, SW 4, branch 3; each wait cycle adds exactly one cycle.
REQ-020 HALT SHALL be sticky until reset, with halted=1 and all enables, requests and write strobes 0.
REQ-021 pc_en, ir_en and reg_write SHALL never be asserted in the same cycle as an outstanding imem_req or dmem_req wait.
REQ-022 A ready input arriving without an outstanding request SHALL be ignored.

Reset
REQ-023 Assertion of rst SHALL force the state to FETCH and every output to 0 (counters 0, halted 0) immediately, including mid-MEM or mid-FETCH, abandoning the in-flight request.
REQ-024 The first imem_req SHALL assert in the first clock after rst deasserts.

Configuration
REQ-025 With MULTICYCLE_CTRL_PERF_EN defined, cycle_cnt SHALL increment every non-HALT cycle and instr_cnt SHALL increment on each pc_en pulse, both wrapping modulo 2^DATA_WIDTH.
REQ-026 Without MULTICYCLE_CTRL_PERF_EN, cycle_cnt and instr_cnt SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-027 The package multicycle_pkg SHALL hold the state enum, the opcode constants, the alu_ctrl encoding (ADD=000, SUB=001, AND=010, OR=011, SLT=100), and the imm_src encoding.
REQ-028 The combinational opcode/funct decoder SHALL be the single sub-module mc_decoder, which outputs the controls plus an illegal flag.

Verification
REQ-029 Zero-wait ADDI 0x00500093 -> ir_en in cycle 1; alu_src=1, alu_ctrl=000, imm_src=00; reg_write and pc_en together in cycle 4; instr_cnt=1.
REQ-030 BEQ 0x00000063 with eq=1 -> pc_en and pc_src=1 in cycle 3; with eq=0 -> pc_src=0; no reg_write in either case.
REQ-031 LW 0x0000A103 with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0; WB has result_src=1; total 8 cycles.
REQ-032 Instruction 0x00000000 -> HALT after DECODE; halted=1 for 20 further cycles; imem_req stays 0; cycle_cnt frozen.
REQ-033 rst pulled low mid-MEM during SW 0x00112023 -> dmem_req and dmem_we drop asynchronously; after release, imem_req=1 next cycle and counters=0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcode constants, ALU/immediate select encodings and the latched control
// bundle produced by the decoder.
package multicycle_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    typedef enum logic [2:0] {
        CLS_R  = 3'd0,
        CLS_I  = 3'd1,
        CLS_LW = 3'd2,
        CLS_SW = 3'd3,
        CLS_BR = 3'd4
    } instr_cls_e;

    typedef struct packed {
        instr_cls_e cls;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic [1:0] imm_src;
        logic       inv_eq;     // BNE: branch taken on !eq
    } ctrl_t;

    // funct3 -> ALU op shared by R-type and I-type; MSB flags a supported funct3
    function automatic logic [3:0] alu_op_f3(input logic [2:0] f3);
        case (f3)
            3'b000:  return {1'b1, ALU_ADD};
            3'b111:  return {1'b1, ALU_AND};
            3'b110:  return {1'b1, ALU_OR};
            3'b010:  return {1'b1, ALU_SLT};
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mc_decoder.sv
// Combinational opcode/funct decoder. Produces the control bundle for one
// instruction and flags every unsupported opcode/funct3/funct7 combination.
module mc_decoder
    import multicycle_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] f3op;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign f3            = instr[14:12];
    assign f7            = instr[31:25];
    assign f3op          = alu_op_f3(f3);
    // register/immediate fields are routed by the datapath, not decoded here
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // decode opcode class, ALU op, operand and immediate selects
    always_comb begin
        ctrl          = '0;
        ctrl.cls      = CLS_R;
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.imm_src  = IMM_I;
        illegal       = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                ctrl.cls = CLS_R;
                if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    ctrl.alu_ctrl = ALU_SUB;
                    illegal       = 1'b0;
                end else if (f7 == 7'b0000000 && f3op[3]) begin
                    ctrl.alu_ctrl = f3op[2:0];
                    illegal       = 1'b0;
                end
            end
            OP_ITYPE: begin
                ctrl.cls      = CLS_I;
                ctrl.alu_src  = 1'b1;
                ctrl.alu_ctrl = f3op[2:0];
                illegal       = !f3op[3];
            end
            OP_LOAD: begin
                ctrl.cls     = CLS_LW;
                ctrl.alu_src = 1'b1;
                illegal      = (f3 != 3'b010);
            end
            OP_STORE: begin
                ctrl.cls     = CLS_SW;
                ctrl.alu_src = 1'b1;
                ctrl.imm_src = IMM_S;
                illegal      = (f3 != 3'b010);
            end
            OP_BRANCH: begin
                ctrl.cls      = CLS_BR;
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.imm_src  = IMM_B;
                ctrl.inv_eq   = f3[0];
                illegal       = (f3[2:1] != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky
// HALT on illegal instructions. Optional cycle/instruction counters are
// built only when MULTICYCLE_CTRL_PERF_EN is defined.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    output logic                  imem_req,
    input  logic                  imem_ready,
    output logic                  dmem_req,
    output logic                  dmem_we,
    input  logic                  dmem_ready,
    input  logic                  eq,
    output logic                  ir_en,
    output logic                  pc_en,
    output logic                  pc_src,
    output logic                  reg_write,
    output logic                  alu_src,
    output logic                  result_src,
    output logic [2:0]            alu_ctrl,
    output logic [1:0]            imm_src,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] cycle_cnt,
    output logic [DATA_WIDTH-1:0] instr_cnt
);

    state_e state_q, state_d;
    ctrl_t  dec_ctrl, ctrl_q;
    logic   dec_illegal;
    // low while reset is held and until the first edge after release, so
    // every output is forced to 0 asynchronously without using rst as data
    logic   armed_q;

    mc_decoder u_dec (
        .instr   (instr[31:0]),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // state register and arm flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    // capture decoded controls for use through EXEC/MEM/WB
    always_ff @(posedge clk) begin
        if (state_q == DECODE) ctrl_q <= dec_ctrl;
    end

    // next-state and control outputs
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        result_src = 1'b0;
        alu_ctrl   = ALU_ADD;
        imm_src    = IMM_I;
        halted     = 1'b0;
        if (armed_q) begin
            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_en   = 1'b1;
                        state_d = DECODE;
                    end
                end
                DECODE: state_d = dec_illegal ? HALT : EXEC;
                EXEC: begin
                    alu_src  = ctrl_q.alu_src;
                    alu_ctrl = ctrl_q.alu_ctrl;
                    imm_src  = ctrl_q.imm_src;
                    case (ctrl_q.cls)
                        CLS_R, CLS_I:   state_d = WB;
                        CLS_LW, CLS_SW: state_d = MEM;
                        CLS_BR: begin
                            pc_en   = 1'b1;
                            pc_src  = ctrl_q.inv_eq ? !eq : eq;
                            state_d = FETCH;
                        end
                        default:        state_d = HALT;
                    endcase
                end
                MEM: begin
                    alu_src  = ctrl_q.alu_src;
                    alu_ctrl = ctrl_q.alu_ctrl;
                    imm_src  = ctrl_q.imm_src;
                    dmem_req = 1'b1;
                    dmem_we  = (ctrl_q.cls == CLS_SW);
                    if (dmem_ready) begin
                        if (ctrl_q.cls == CLS_SW) begin
                            pc_en   = 1'b1;
                            state_d = FETCH;
                        end else begin
                            state_d = WB;
                        end
                    end
                end
                WB: begin
                    alu_src    = ctrl_q.alu_src;
                    alu_ctrl   = ctrl_q.alu_ctrl;
                    imm_src    = ctrl_q.imm_src;
                    reg_write  = 1'b1;
                    pc_en      = 1'b1;
                    result_src = (ctrl_q.cls == CLS_LW);
                    state_d    = FETCH;
                end
                HALT:    halted = 1'b1;
                default: state_d = FETCH;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [DATA_WIDTH-1:0] cycle_q, instr_q;

    // free-running cycle and retired-instruction counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (armed_q && state_q != HALT) cycle_q <= cycle_q + DATA_WIDTH'(1);
            if (pc_en) instr_q <= instr_q + DATA_WIDTH'(1);
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: latency, control values, handshakes,
// illegal-instruction halt and asynchronous reset.
module tb_multicycle_ctrl;

    logic        clk, rst;
    logic [31:0] instr;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, eq;
    logic        ir_en, pc_en, pc_src, reg_write, alu_src, result_src, halted;
    logic [2:0]  alu_ctrl;
    logic [1:0]  imm_src;
    logic [31:0] cycle_cnt, instr_cnt;
    logic [13:0] all_outs;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cc, exp_ic;
    int r_ir, r_pc, r_rw_cyc, r_nrw, r_ndreq, r_we, r_rs, r_pcsrc;
    int r_alusrc, r_aluctrl, r_imm, r_viol, r_req1, r_ic1, r_cc1;
    int h_n, h_bad, h_cc3, h_cc22;

    multicycle_ctrl #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .instr(instr),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .eq(eq), .ir_en(ir_en), .pc_en(pc_en), .pc_src(pc_src),
        .reg_write(reg_write), .alu_src(alu_src), .result_src(result_src),
        .alu_ctrl(alu_ctrl), .imm_src(imm_src), .halted(halted),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    assign all_outs = {halted, imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_src,
                       reg_write, alu_src, result_src, alu_ctrl, imm_src};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int perf(input int v);
`ifdef MULTICYCLE_CTRL_PERF_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_outs", int'(all_outs), 0);
        check_eq("rst_cycle_cnt", int'(cycle_cnt), 0);
        check_eq("rst_instr_cnt", int'(instr_cnt), 0);
        rst = 1'b1;
        exp_cc = 0;
        exp_ic = 0;
    endtask

    // one instruction, memories answering after iw / dw wait cycles
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw,
                             input logic eq_v, input bit noise);
        r_ir = 0; r_pc = 0; r_rw_cyc = 0; r_nrw = 0; r_ndreq = 0; r_we = 0;
        r_rs = 0; r_pcsrc = 0; r_alusrc = -1; r_aluctrl = -1; r_imm = -1;
        r_viol = 0; r_req1 = 0; r_ic1 = -1; r_cc1 = -1;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            instr      = ins;
            eq         = eq_v;
            imem_ready = (c == 1 + iw) || (noise && c > 1 + iw);
            dmem_ready = noise ? 1'b1 : (c == 4 + iw + dw);
            @(negedge clk);
            if (c == 1) begin
                r_req1 = int'(imem_req);
                r_ic1  = int'(instr_cnt);
                r_cc1  = int'(cycle_cnt);
            end
            if (ir_en && r_ir == 0) r_ir = c;
            if (c == 3 + iw) begin
                r_alusrc  = int'(alu_src);
                r_aluctrl = int'(alu_ctrl);
                r_imm     = int'(imm_src);
            end
            if (reg_write) begin
                r_nrw++;
                r_rw_cyc = c;
                r_rs = int'(result_src);
            end
            if (dmem_req) r_ndreq++;
            if (dmem_we) r_we = 1;
            if ((pc_en || ir_en || reg_write) &&
                ((imem_req && !imem_ready) || (dmem_req && !dmem_ready))) r_viol++;
            if (pc_en) begin
                r_pc = c;
                r_pcsrc = int'(pc_src);
                break;
            end
        end
        check_eq("cc_at_fetch", r_cc1, perf(exp_cc));
        check_eq("ic_at_fetch", r_ic1, perf(exp_ic));
        check_eq("handshake_rule", r_viol, 0);
        exp_ic++;
    endtask

    task automatic run_halt(input logic [31:0] ins);
        h_n = 0; h_bad = 0; h_cc3 = -1; h_cc22 = -1;
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk);
            #1;
            instr      = ins;
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            @(negedge clk);
            if (c >= 3) begin
                h_n += int'(halted);
                h_bad += int'(imem_req | dmem_req | dmem_we | ir_en | pc_en | reg_write);
            end
            if (c == 3) h_cc3 = int'(cycle_cnt);
            if (c == 22) h_cc22 = int'(cycle_cnt);
        end
        check_eq("halt_cycles", h_n, 20);
        check_eq("halt_quiet", h_bad, 0);
        check_eq("halt_cc_entry", h_cc3, perf(exp_cc + 2));
        check_eq("halt_cc_frozen", h_cc22, perf(exp_cc + 2));
    endtask

    logic [31:0] alu_ins [8];
    int          alu_exp [8];
    int          alu_isi [8];
    logic [31:0] br_ins  [4];
    logic        br_eq   [4];
    int          br_exp  [4];

    initial begin
        alu_ins = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                    32'h0020A1B3, 32'h0070F093, 32'h0030E093, 32'hFFF0A093};
        alu_exp = '{0, 1, 2, 3, 4, 2, 3, 4};
        alu_isi = '{0, 0, 0, 0, 0, 1, 1, 1};
        br_ins  = '{32'h00000063, 32'h00000063, 32'h00001063, 32'h00001063};
        br_eq   = '{1'b1, 1'b0, 1'b0, 1'b1};
        br_exp  = '{1, 0, 1, 0};

        rst = 1'b0; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0; eq = 1'b0;
        do_reset();

        // ADDI x1, x0, 5 with zero-wait memory
        run_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
        check_eq("addi_req_first", r_req1, 1);
        check_eq("addi_ir_cyc", r_ir, 1);
        check_eq("addi_pc_cyc", r_pc, 4);
        check_eq("addi_rw_cyc", r_rw_cyc, 4);
        check_eq("addi_rw_cnt", r_nrw, 1);
        check_eq("addi_alu_src", r_alusrc, 1);
        check_eq("addi_alu_ctrl", r_aluctrl, 0);
        check_eq("addi_imm_src", r_imm, 0);
        check_eq("addi_pc_src", r_pcsrc, 0);
        check_eq("addi_result_src", r_rs, 0);
        check_eq("addi_dmem", r_ndreq, 0);
        exp_cc += 4;

        // R-type and I-type ALU ops, with fetch waits and stray ready pulses
        for (int i = 0; i < 8; i++) begin
            run_instr(alu_ins[i], i % 3, 0, 1'b0, bit'(i % 2));
            check_eq($sformatf("alu%0d_ir_cyc", i), r_ir, 1 + i % 3);
            check_eq($sformatf("alu%0d_pc_cyc", i), r_pc, 4 + i % 3);
            check_eq($sformatf("alu%0d_rw_cnt", i), r_nrw, 1);
            check_eq($sformatf("alu%0d_alu_ctrl", i), r_aluctrl, alu_exp[i]);
            check_eq($sformatf("alu%0d_alu_src", i), r_alusrc, alu_isi[i]);
            check_eq($sformatf("alu%0d_dmem", i), r_ndreq, 0);
            exp_cc += 4 + i % 3;
        end

        // BEQ / BNE taken and not taken
        for (int i = 0; i < 4; i++) begin
            run_instr(br_ins[i], i % 2, 0, br_eq[i], 1'b0);
            check_eq($sformatf("br%0d_pc_cyc", i), r_pc, 3 + i % 2);
            check_eq($sformatf("br%0d_pc_src", i), r_pcsrc, br_exp[i]);
            check_eq($sformatf("br%0d_rw_cnt", i), r_nrw, 0);
            check_eq($sformatf("br%0d_alu_ctrl", i), r_aluctrl, 1);
            check_eq($sformatf("br%0d_alu_src", i), r_alusrc, 0);
            check_eq($sformatf("br%0d_imm_src", i), r_imm, 2);
            exp_cc += 3 + i % 2;
        end

        // SW zero-wait
        run_instr(32'h00112023, 0, 0, 1'b0, 1'b0);
        check_eq("sw_pc_cyc", r_pc, 4);
        check_eq("sw_dreq_cyc", r_ndreq, 1);
        check_eq("sw_we", r_we, 1);
        check_eq("sw_rw_cnt", r_nrw, 0);
        check_eq("sw_imm_src", r_imm, 1);
        check_eq("sw_alu_src", r_alusrc, 1);
        check_eq("sw_pc_src", r_pcsrc, 0);
        exp_cc += 4;

        // LW with data memory answering 3 cycles late
        run_instr(32'h0000A103, 0, 3, 1'b0, 1'b0);
        check_eq("lw_dreq_cyc", r_ndreq, 4);
        check_eq("lw_we", r_we, 0);
        check_eq("lw_result_src", r_rs, 1);
        check_eq("lw_rw_cyc", r_rw_cyc, 8);
        check_eq("lw_pc_cyc", r_pc, 8);
        check_eq("lw_imm_src", r_imm, 0);
        exp_cc += 8;

        // SW with one fetch wait and two data waits
        run_instr(32'h00112023, 1, 2, 1'b0, 1'b0);
        check_eq("sw2_pc_cyc", r_pc, 7);
        check_eq("sw2_dreq_cyc", r_ndreq, 3);
        exp_cc += 7;

        // all-zero word is illegal: sticky halt
        run_halt(32'h00000000);
        do_reset();

        // SUB-style funct7 with AND funct3 is illegal
        run_halt(32'h4020F1B3);
        do_reset();

        // reset pulled mid-MEM during a stalled SW
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            instr      = 32'h00112023;
            imem_ready = (c == 1);
            dmem_ready = 1'b0;
            @(negedge clk);
        end
        check_eq("midmem_dreq", int'(dmem_req), 1);
        check_eq("midmem_we", int'(dmem_we), 1);
        #2 rst = 1'b0;
        #1;
        check_eq("midmem_rst_dreq", int'(dmem_req), 0);
        check_eq("midmem_rst_we", int'(dmem_we), 0);
        check_eq("midmem_rst_outs", int'(all_outs), 0);
        repeat (2) @(negedge clk);
        check_eq("midmem_rst_cc", int'(cycle_cnt), 0);
        check_eq("midmem_rst_ic", int'(instr_cnt), 0);
        rst = 1'b1;
        exp_cc = 0;
        exp_ic = 0;
        run_instr(32'h00500093, 0, 0, 1'b0, 1'b0);
        check_eq("post_rst_req", r_req1, 1);
        check_eq("post_rst_ir_cyc", r_ir, 1);
        check_eq("post_rst_pc_cyc", r_pc, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
